demux_1by8_sync: RTL and testbench

Registered 1-to-8 demultiplexer and serial-to-parallel collector. It is the receive-side counterpart of the team's 8:1 bit-select multiplexer. Single-bit beats are steered into one of N output lanes, either by an explicit lane address or by an internal scan pointer. Once every lane has been written, the assembled word is presented with a valid/ready handshake. It sits wherever a muxed or serialised bit stream must be fanned back out into a parallel word.

---
 rtl/mux_pkg.sv | 16 +
 rtl/lane_decoder.sv | 23 ++
 rtl/demux_1by8_sync.sv | 128 ++++++++++++
 tb/tb_demux_1by8_sync.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg
//   Types and constants shared by the demux/mux family of blocks.
//   state_e   : collector FSM states (COLLECT accepting beats, HOLD presenting a frame)
//   MODE_ADDR : lane chosen by the explicit address input
//   MODE_SCAN : lane chosen by the internal scan pointer
package mux_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

endpackage : mux_pkg

// File: rtl/lane_decoder.sv
// lane_decoder
//   Combinational one-hot write-strobe generator for demux-style blocks.
//   Ports:
//     idx_i    [SEL_W-1:0]  lane index
//     en_i                  strobe enable; all strobes low when 0
//     strobe_o [N-1:0]      one-hot strobe, bit idx_i set when enabled
module lane_decoder #(
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [SEL_W-1:0] idx_i,
   input  logic             en_i,
   output logic [N-1:0]     strobe_o
);

   always_comb begin
      strobe_o = '0;
      if (en_i) begin
         strobe_o[idx_i] = 1'b1;
      end
   end

endmodule : lane_decoder

// File: rtl/demux_1by8_sync.sv
// demux_1by8_sync
//   Registered 1-to-N demultiplexer / serial-to-parallel collector. Single-bit
//   beats are steered to a lane chosen by sel (addressed mode) or by an internal
//   scan pointer (auto-scan mode). Once every lane has been written the word is
//   presented on data_out with a frame_valid/frame_ready handshake.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     data_in      serial bit
//     in_valid     beat qualifier for data_in/sel/mode
//     in_ready     beat accepted when in_valid & in_ready
//     sel          lane address (addressed mode only)
//     mode         0 = addressed, 1 = auto-scan; sampled on first beat of a frame
//     data_out     assembled word, bit i = lane i
//     lane_mask    lanes written in the current frame
//     frame_valid  data_out holds a complete frame
//     frame_ready  consumer takes the frame
module demux_1by8_sync
   import mux_pkg::*;
#(
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] sel,
   input  logic             mode,
   output logic [N-1:0]     data_out,
   output logic [N-1:0]     lane_mask,
   output logic             frame_valid,
   input  logic             frame_ready
);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q,   ptr_d;
   logic               mode_q,  mode_d;
   logic [N-1:0]       mask_q,  mask_d;
   logic [N-1:0]       data_q,  data_d;

   logic               accept;
   logic               first_beat;
   logic               eff_mode;
   logic [SEL_W-1:0]   lane;
   logic [N-1:0]       strobe;
   logic               frame_done;

   assign accept     = in_valid & in_ready;
   assign first_beat = (mask_q == '0);
   // The live mode input only matters on the opening beat; afterwards the
   // latched copy steers the rest of the frame.
   assign eff_mode   = first_beat ? mode : mode_q;
   assign lane       = (eff_mode == MODE_SCAN) ? ptr_q : sel;
   assign frame_done = accept & ((mask_q | strobe) == '1);

   lane_decoder #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_lane_decoder (
      .idx_i    (lane),
      .en_i     (accept),
      .strobe_o (strobe)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COLLECT;
         ptr_q   <= '0;
         mode_q  <= MODE_ADDR;
         mask_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mode_q  <= mode_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mode_d  = mode_q;
      mask_d  = mask_q;
      data_d  = data_q;
      unique case (state_q)
         COLLECT: begin
            if (accept) begin
               if (first_beat) begin
                  mode_d = mode;
               end
               if (eff_mode == MODE_SCAN) begin
                  ptr_d = ptr_q + SEL_W'(1);
               end
               // Overwriting an already-written lane leaves the mask unchanged,
               // so repeats earn no completion credit.
               mask_d = mask_q | strobe;
               data_d = (data_q & ~strobe) | ({N{data_in}} & strobe);
               if (frame_done) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Lanes keep the last frame; only the bookkeeping restarts.
            if (frame_ready) begin
               state_d = COLLECT;
               mask_d  = '0;
               ptr_d   = '0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready    = (state_q == COLLECT) & ~rst;
      frame_valid = (state_q == HOLD);
      data_out    = data_q;
      lane_mask   = mask_q;
   end

endmodule : demux_1by8_sync

// File: tb/tb_demux_1by8_sync.sv
module tb_demux_1by8_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic       data_in;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] sel;
   logic       mode;
   logic [7:0] data_out;
   logic [7:0] lane_mask;
   logic       frame_valid;
   logic       frame_ready;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   demux_1by8_sync u_dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sel         (sel),
      .mode        (mode),
      .data_out    (data_out),
      .lane_mask   (lane_mask),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one beat for one clock edge, then sample #1 after the edge.
   task automatic beat(input logic d, input logic m, input logic [2:0] s);
      in_valid = 1'b1;
      data_in  = d;
      mode     = m;
      sel      = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] bits;
   logic [7:0] exp_mask;
   logic [2:0] order [8];

   initial begin
      rst = 1'b1; data_in = 1'b0; in_valid = 1'b0; sel = '0; mode = 1'b0; frame_ready = 1'b1;
      tick(); tick();
      chk("rst_data", data_out, 8'h00);
      chk("rst_mask", lane_mask, 8'h00);
      chk("rst_fv", frame_valid, 1'b0);
      chk("rst_rdy", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("rdy_after_rst", in_ready, 1'b1);

      // 1: auto-scan 1,0,1,1,0,0,1,0 to lanes 0..7 -> 8'b0100_1101
      bits = 8'b0100_1101;
      for (int i = 0; i < 8; i++) begin
         beat(bits[i], 1'b1, 3'd0);
         if (i == 6) chk("t1_fv_early", frame_valid, 1'b0);
      end
      chk("t1_fv", frame_valid, 1'b1);
      chk("t1_data", data_out, 8'h4D);
      chk("t1_rdy_hold", in_ready, 1'b0);
      tick();
      chk("t1_fv_drop", frame_valid, 1'b0);
      chk("t1_rdy_back", in_ready, 1'b1);
      chk("t1_mask_clr", lane_mask, 8'h00);

      // 2: addressed, out-of-order lanes, all ones
      order = '{3'd7, 3'd0, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
      exp_mask = 8'h00;
      for (int i = 0; i < 8; i++) begin
         beat(1'b1, 1'b0, order[i]);
         exp_mask = exp_mask | (8'h01 << order[i]);
         if (i < 7) begin
            chk("t2_mask", lane_mask, exp_mask);
            chk("t2_fv_early", frame_valid, 1'b0);
         end
      end
      chk("t2_fv", frame_valid, 1'b1);
      chk("t2_data", data_out, 8'hFF);
      tick();

      // 3: overwrite lane 2, then fill the rest -> 8'hFB
      beat(1'b1, 1'b0, 3'd2);
      beat(1'b0, 1'b0, 3'd2);
      chk("t3_mask_rep", lane_mask, 8'h04);
      chk("t3_lane2", data_out[2], 1'b0);
      order = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd7};
      for (int i = 0; i < 8; i++) begin
         if (i == 6) continue;
         beat(1'b1, 1'b0, order[i]);
         if (i == 5) chk("t3_fv_early", frame_valid, 1'b0);
      end
      chk("t3_fv", frame_valid, 1'b1);
      chk("t3_data", data_out, 8'hFB);
      tick();

      // 4: backpressure, scan 1,1,0,0,1,1,0,0 -> 8'h33
      frame_ready = 1'b0;
      bits = 8'h33;
      for (int i = 0; i < 8; i++) beat(bits[i], 1'b1, 3'd0);
      chk("t4_fv", frame_valid, 1'b1);
      in_valid = 1'b1; data_in = 1'b0; mode = 1'b0; sel = 3'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_fv_hold", frame_valid, 1'b1);
         chk("t4_data_hold", data_out, 8'h33);
         chk("t4_rdy_hold", in_ready, 1'b0);
         chk("t4_mask_hold", lane_mask, 8'hFF);
      end
      frame_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t4_rdy_back", in_ready, 1'b1);
      chk("t4_mask_clr", lane_mask, 8'h00);
      chk("t4_fv_drop", frame_valid, 1'b0);
      chk("t4_data_keep", data_out, 8'h33);

      // 5: mode flips to addressed/sel=7 after 3 beats; scan continues -> 8'h96
      bits = 8'h96;
      for (int i = 0; i < 8; i++) begin
         if (i < 3) beat(bits[i], 1'b1, 3'd0);
         else       beat(bits[i], 1'b0, 3'd7);
         if (i == 6) chk("t5_mask7", lane_mask, 8'h7F);
      end
      chk("t5_fv", frame_valid, 1'b1);
      chk("t5_data", data_out, 8'h96);
      tick();

      // 6: reset after 4 scan beats, then a fresh scan from lane 0 -> 8'h0F
      bits = 8'h05;
      for (int i = 0; i < 4; i++) beat(bits[i], 1'b1, 3'd0);
      chk("t6_mask_part", lane_mask, 8'h0F);
      rst = 1'b1;
      tick();
      chk("t6_rst_data", data_out, 8'h00);
      chk("t6_rst_mask", lane_mask, 8'h00);
      chk("t6_rst_fv", frame_valid, 1'b0);
      chk("t6_rst_rdy", in_ready, 1'b0);
      rst = 1'b0;
      bits = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         beat(bits[i], 1'b1, 3'd5);
         if (i == 0) chk("t6_first_lane", lane_mask, 8'h01);
      end
      chk("t6_fv", frame_valid, 1'b1);
      chk("t6_data", data_out, 8'h0F);
      tick();
      chk("t6_fv_drop", frame_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_demux_1by8_sync
